// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Sequential ALU. Logic/add/sub/compare complete in one cycle;
//             unsigned MUL (shift-add) and DIV (restoring) iterate one bit
//             per cycle over WIDTH cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [WIDTH-1:0] ScrA,
   input  logic [WIDTH-1:0] ScrB,
   input  logic [2:0]       Alu_Control,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Alu_Result,
   output logic [WIDTH-1:0] Alu_Hi,
   output logic             Zero_flag,
   output logic             Overflow,
   output logic             Div_By_Zero
);

   localparam logic [2:0] c_OP_AND  = 3'b000;
   localparam logic [2:0] c_OP_OR   = 3'b001;
   localparam logic [2:0] c_OP_ADD  = 3'b010;
   localparam logic [2:0] c_OP_DIV  = 3'b011;
   localparam logic [2:0] c_OP_SUB  = 3'b100;
   localparam logic [2:0] c_OP_MUL  = 3'b101;
   localparam logic [2:0] c_OP_SLT  = 3'b110;
   localparam logic [2:0] c_OP_SLTU = 3'b111;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   localparam int c_MSB = WIDTH - 1;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [2*WIDTH-1:0] r_p;          // {hi, lo}: product or {remainder, quotient}
   logic [WIDTH-1:0]   r_m;          // latched multiplicand / divisor
   logic               r_is_div;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   r_hi;
   logic               r_ovf;
   logic               r_dbz;

   logic               w_accept;
   logic               w_iter;
   logic               w_last;
   logic [WIDTH-1:0]   w_sum;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_fast_result;
   logic [WIDTH-1:0]   w_fast_hi;
   logic               w_fast_ovf;
   logic               w_fast_dbz;
   logic [WIDTH:0]     w_mul_add;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_trial;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_step_next;

   // A new request is taken whenever no iterative op is in flight
   assign w_accept = Start && (r_state != c_RUN);
   // Divide by zero short-circuits to the single-cycle path
   assign w_iter   = (Alu_Control == c_OP_MUL) ||
                     ((Alu_Control == c_OP_DIV) && (ScrB != '0));
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   assign w_sum  = ScrA + ScrB;
   assign w_diff = ScrA - ScrB;

   // Single-cycle operation results
   always_comb begin
      w_fast_result = '0;
      w_fast_hi     = '0;
      w_fast_ovf    = 1'b0;
      w_fast_dbz    = 1'b0;
      case (Alu_Control)
         c_OP_AND:  w_fast_result = ScrA & ScrB;
         c_OP_OR:   w_fast_result = ScrA | ScrB;
         c_OP_ADD: begin
            w_fast_result = w_sum;
            w_fast_ovf    = (ScrA[c_MSB] == ScrB[c_MSB]) && (w_sum[c_MSB] != ScrA[c_MSB]);
         end
         c_OP_SUB: begin
            w_fast_result = w_diff;
            w_fast_ovf    = (ScrA[c_MSB] != ScrB[c_MSB]) && (w_diff[c_MSB] != ScrA[c_MSB]);
         end
         c_OP_DIV: begin
            // only reached with a zero divisor
            w_fast_result = '1;
            w_fast_hi     = ScrA;
            w_fast_dbz    = 1'b1;
         end
         c_OP_SLT:  w_fast_result = {{(WIDTH-1){1'b0}}, ($signed(ScrA) < $signed(ScrB))};
         c_OP_SLTU: w_fast_result = {{(WIDTH-1){1'b0}}, (ScrA < ScrB)};
         default:   w_fast_result = '0;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide
   always_comb begin
      w_mul_add   = r_p[0] ? ({1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m})
                           : {1'b0, r_p[2*WIDTH-1:WIDTH]};
      w_mul_next  = {w_mul_add, r_p[WIDTH-1:1]};
      w_rem_sh    = r_p[2*WIDTH-1:WIDTH-1];
      w_trial     = w_rem_sh - {1'b0, r_m};
      w_div_next  = w_trial[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                   : {w_trial[WIDTH-1:0],  r_p[WIDTH-2:0], 1'b1};
      w_step_next = r_is_div ? w_div_next : w_mul_next;
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= c_IDLE;
      else      r_state <= w_state_next;
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE, c_DONE: begin
            if (Start) w_state_next = w_iter ? c_RUN : c_DONE;
            else       w_state_next = c_IDLE;
         end
         c_RUN:   w_state_next = w_last ? c_DONE : c_RUN;
         default: w_state_next = c_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      Busy = (r_state == c_RUN);
      Done = (r_state == c_DONE);
   end

   // Iteration datapath: operand latch on acceptance, one step per RUN cycle
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_p      <= '0;
         r_m      <= '0;
         r_is_div <= 1'b0;
         r_cnt    <= '0;
      end else if (w_accept && w_iter) begin
         r_p      <= {{WIDTH{1'b0}}, ScrA};
         r_m      <= ScrB;
         r_is_div <= (Alu_Control == c_OP_DIV);
         r_cnt    <= '0;
      end else if (r_state == c_RUN) begin
         r_p      <= w_step_next;
         r_cnt    <= r_cnt + 1'b1;
      end
   end

   // Result registers change only when an operation completes
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_result <= '0;
         r_hi     <= '0;
         r_ovf    <= 1'b0;
         r_dbz    <= 1'b0;
      end else if (w_accept && !w_iter) begin
         r_result <= w_fast_result;
         r_hi     <= w_fast_hi;
         r_ovf    <= w_fast_ovf;
         r_dbz    <= w_fast_dbz;
      end else if ((r_state == c_RUN) && w_last) begin
         r_result <= w_step_next[WIDTH-1:0];
         r_hi     <= w_step_next[2*WIDTH-1:WIDTH];
         r_ovf    <= 1'b0;
         r_dbz    <= 1'b0;
      end
   end

   assign Alu_Result  = r_result;
   assign Alu_Hi      = r_hi;
   assign Overflow    = r_ovf;
   assign Div_By_Zero = r_dbz;
   assign Zero_flag   = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (WIDTH=32) with directed
//             scenarios and randomized ops against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
   localparam int W = 32;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_SLTU = 3'b111;

   logic         CLK = 1'b0;
   logic         RST;
   logic         Start;
   logic [W-1:0] ScrA;
   logic [W-1:0] ScrB;
   logic [2:0]   Alu_Control;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Alu_Result;
   logic [W-1:0] Alu_Hi;
   logic         Zero_flag;
   logic         Overflow;
   logic         Div_By_Zero;

   int total = 0;
   int bad   = 0;

   alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .ScrA(ScrA), .ScrB(ScrB),
      .Alu_Control(Alu_Control), .Busy(Busy), .Done(Done),
      .Alu_Result(Alu_Result), .Alu_Hi(Alu_Hi), .Zero_flag(Zero_flag),
      .Overflow(Overflow), .Div_By_Zero(Div_By_Zero)
   );

   always #5 CLK = ~CLK;

   // Reference model: plain arithmetic on the operation's meaning
   task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic [W-1:0] hi,
                        output logic ovf, output logic dbz, output int lat);
      longint sa, sb, s;
      logic [63:0] prod;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0; hi = '0; ovf = 1'b0; dbz = 1'b0; lat = 1;
      case (op)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD:  begin s = sa + sb; res = W'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         OP_SUB:  begin s = sa - sb; res = W'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         OP_SLT:  res = (sa < sb) ? 1 : 0;
         OP_SLTU: res = (a < b) ? 1 : 0;
         OP_MUL:  begin prod = {32'b0, a} * {32'b0, b}; res = prod[31:0]; hi = prod[63:32]; lat = W + 1; end
         default: begin
            if (b == 0) begin res = '1; hi = a; dbz = 1'b1; end
            else begin res = a / b; hi = a % b; lat = W + 1; end
         end
      endcase
   endtask

   // Issue one op and wait (bounded) for Done; lat counts cycles after the accepting edge
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_n);
      @(negedge CLK);
      Start = 1'b1; Alu_Control = op; ScrA = a; ScrB = b;
      @(posedge CLK); #1;
      Start = 1'b0;
      lat = 1; busy_n = 0;
      while (Done !== 1'b1 && lat < 100) begin
         if (Busy === 1'b1) busy_n++;
         @(posedge CLK); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      RST = 1'b0; Start = 1'b0; Alu_Control = OP_AND; ScrA = '0; ScrB = '0;
      repeat (3) @(posedge CLK);
      #1;
      total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
      total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", Done); end
      total++; if (Alu_Result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", Alu_Result); end
      total++; if (Alu_Hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", Alu_Hi); end
      total++; if (Zero_flag !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", Zero_flag); end
      total++; if ({Overflow, Div_By_Zero} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {Overflow, Div_By_Zero}); end
      @(negedge CLK); RST = 1'b1;
      @(posedge CLK); #1;
      total++; if ({Busy, Done} !== 2'b00) begin bad++; $display("FAIL idle_after_reset: got %b want 00", {Busy, Done}); end
   endtask

   task automatic test_add_overflow;
      int lat, bn;
      run_op(OP_ADD, 32'h7FFFFFFF, 32'h1, lat, bn);
      total++; if (lat != 1) begin bad++; $display("FAIL add_latency: got %0d want 1", lat); end
      total++; if (Alu_Result !== 32'h80000000) begin bad++; $display("FAIL add_result: got %h want 80000000", Alu_Result); end
      total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL add_ovf: got %b want 1", Overflow); end
      total++; if (Zero_flag !== 1'b0) begin bad++; $display("FAIL add_zero: got %b want 0", Zero_flag); end
      @(posedge CLK); #1;
      total++; if (Done !== 1'b0) begin bad++; $display("FAIL add_done_pulse: got %b want 0", Done); end
      total++; if (Alu_Result !== 32'h80000000) begin bad++; $display("FAIL add_hold: got %h want 80000000", Alu_Result); end
   endtask

   task automatic test_slt;
      int lat, bn;
      run_op(OP_SLT, 32'hFFFFFFFF, 32'h1, lat, bn);
      total++; if (Alu_Result !== 32'h1) begin bad++; $display("FAIL slt_result: got %h want 1", Alu_Result); end
      run_op(OP_SLTU, 32'hFFFFFFFF, 32'h1, lat, bn);
      total++; if (Alu_Result !== 32'h0) begin bad++; $display("FAIL sltu_result: got %h want 0", Alu_Result); end
      total++; if (Zero_flag !== 1'b1) begin bad++; $display("FAIL sltu_zero: got %b want 1", Zero_flag); end
   endtask

   task automatic test_mul;
      int lat, bn;
      @(negedge CLK);
      Start = 1'b1; Alu_Control = OP_MUL; ScrA = 32'hFFFFFFFF; ScrB = 32'h2;
      @(posedge CLK); #1;
      Start = 1'b0; lat = 1; bn = 0;
      while (Done !== 1'b1 && lat < 100) begin
         if (Busy === 1'b1) bn++;
         // a competing AND request in the middle of RUN must be ignored
         if (lat == 5) begin Start = 1'b1; Alu_Control = OP_AND; ScrA = 32'h0; ScrB = 32'h0; end
         else Start = 1'b0;
         @(posedge CLK); #1;
         lat++;
      end
      Start = 1'b0;
      total++; if (bn != 32) begin bad++; $display("FAIL mul_busy_cycles: got %0d want 32", bn); end
      total++; if (lat != 33) begin bad++; $display("FAIL mul_latency: got %0d want 33", lat); end
      total++; if (Alu_Result !== 32'hFFFFFFFE) begin bad++; $display("FAIL mul_lo: got %h want fffffffe", Alu_Result); end
      total++; if (Alu_Hi !== 32'h1) begin bad++; $display("FAIL mul_hi: got %h want 1", Alu_Hi); end
      @(posedge CLK); #1;
      total++; if (Done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse: got %b want 0", Done); end
   endtask

   task automatic test_div;
      int lat, bn;
      run_op(OP_DIV, 32'd100, 32'd7, lat, bn);
      total++; if (lat != 33) begin bad++; $display("FAIL div_latency: got %0d want 33", lat); end
      total++; if (Alu_Result !== 32'd14) begin bad++; $display("FAIL div_quot: got %0d want 14", Alu_Result); end
      total++; if (Alu_Hi !== 32'd2) begin bad++; $display("FAIL div_rem: got %0d want 2", Alu_Hi); end
      run_op(OP_DIV, 32'd5, 32'd0, lat, bn);
      total++; if (lat != 1) begin bad++; $display("FAIL div0_latency: got %0d want 1", lat); end
      total++; if (Div_By_Zero !== 1'b1) begin bad++; $display("FAIL div0_flag: got %b want 1", Div_By_Zero); end
      total++; if (Alu_Result !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_result: got %h want ffffffff", Alu_Result); end
      total++; if (Alu_Hi !== 32'd5) begin bad++; $display("FAIL div0_hi: got %h want 5", Alu_Hi); end
      run_op(OP_OR, 32'h0F, 32'hF0, lat, bn);
      total++; if (Div_By_Zero !== 1'b0) begin bad++; $display("FAIL div0_clear: got %b want 0", Div_By_Zero); end
      total++; if (Alu_Hi !== 32'h0) begin bad++; $display("FAIL or_hi: got %h want 0", Alu_Hi); end
   endtask

   task automatic test_reset_mid_run;
      int lat, bn, seen_done;
      @(negedge CLK);
      Start = 1'b1; Alu_Control = OP_MUL; ScrA = 32'h12345678; ScrB = 32'h9ABC;
      @(posedge CLK); #1;
      Start = 1'b0;
      repeat (9) @(posedge CLK);
      #1;
      RST = 1'b0;
      #1;
      total++; if ({Busy, Done} !== 2'b00) begin bad++; $display("FAIL rst_run_state: got %b want 00", {Busy, Done}); end
      total++; if (Alu_Result !== 32'h0 || Alu_Hi !== 32'h0) begin bad++; $display("FAIL rst_run_data: got %h/%h want 0/0", Alu_Result, Alu_Hi); end
      total++; if ({Zero_flag, Overflow, Div_By_Zero} !== 3'b100) begin bad++; $display("FAIL rst_run_flags: got %b want 100", {Zero_flag, Overflow, Div_By_Zero}); end
      seen_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         if (Done === 1'b1) seen_done++;
      end
      @(negedge CLK); RST = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK); #1;
         if (Done === 1'b1 || Busy === 1'b1) seen_done++;
      end
      total++; if (seen_done != 0) begin bad++; $display("FAIL rst_run_no_done: got %0d want 0", seen_done); end
      run_op(OP_SUB, 32'd3, 32'd3, lat, bn);
      total++; if (lat != 1) begin bad++; $display("FAIL sub_latency: got %0d want 1", lat); end
      total++; if (Alu_Result !== 32'h0 || Zero_flag !== 1'b1) begin bad++; $display("FAIL sub_zero: got %h z=%b want 0 z=1", Alu_Result, Zero_flag); end
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [63:0] prod;
      prod = {32'b0, 32'hDEADBEEF} * {32'b0, 32'h1234};
      @(negedge CLK);
      Start = 1'b1; Alu_Control = OP_MUL; ScrA = 32'hDEADBEEF; ScrB = 32'h1234;
      @(posedge CLK); #1;
      // Start stays high; the new AND request waits for the DONE cycle
      Alu_Control = OP_AND; ScrA = 32'hF0F0F0F0; ScrB = 32'h3C3C3C3C;
      lat = 1;
      while (Done !== 1'b1 && lat < 100) begin
         @(posedge CLK); #1;
         lat++;
      end
      total++; if (lat != 33) begin bad++; $display("FAIL b2b_mul_latency: got %0d want 33", lat); end
      total++; if ({Alu_Hi, Alu_Result} !== prod) begin bad++; $display("FAIL b2b_mul_result: got %h%h want %h", Alu_Hi, Alu_Result, prod); end
      @(posedge CLK); #1;
      Start = 1'b0;
      total++; if (Done !== 1'b1) begin bad++; $display("FAIL b2b_and_done: got %b want 1", Done); end
      total++; if (Alu_Result !== 32'h30303030 || Alu_Hi !== 32'h0) begin bad++; $display("FAIL b2b_and_result: got %h/%h want 30303030/0", Alu_Result, Alu_Hi); end
      @(posedge CLK); #1;
      total++; if (Done !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", Done); end
   endtask

   task automatic test_random;
      int lat, bn, exp_lat;
      logic [2:0]   op;
      logic [W-1:0] a, b, er, eh;
      logic         eo, ed;
      for (int n = 0; n < 40; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         case ($urandom_range(0, 4))
            0:       b = '0;
            1:       b = a;
            2:       b = 32'($urandom_range(1, 255));
            default: b = $urandom;
         endcase
         model(op, a, b, er, eh, eo, ed, exp_lat);
         run_op(op, a, b, lat, bn);
         total++; if (lat != exp_lat) begin bad++; $display("FAIL rnd_latency op=%0d: got %0d want %0d", op, lat, exp_lat); end
         total++; if (Alu_Result !== er) begin bad++; $display("FAIL rnd_result op=%0d a=%h b=%h: got %h want %h", op, a, b, Alu_Result, er); end
         total++; if (Alu_Hi !== eh) begin bad++; $display("FAIL rnd_hi op=%0d a=%h b=%h: got %h want %h", op, a, b, Alu_Hi, eh); end
         total++; if (Overflow !== eo) begin bad++; $display("FAIL rnd_ovf op=%0d a=%h b=%h: got %b want %b", op, a, b, Overflow, eo); end
         total++; if (Div_By_Zero !== ed) begin bad++; $display("FAIL rnd_dbz op=%0d: got %b want %b", op, Div_By_Zero, ed); end
         total++; if (Zero_flag !== (er == '0)) begin bad++; $display("FAIL rnd_zero op=%0d: got %b want %b", op, Zero_flag, (er == '0)); end
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_slt();
      test_mul();
      test_div();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
